// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: single-outstanding sequencer between EX and the data memory port.
// Checks alignment/range, drives one access cycle, returns a one-cycle response pulse.
module dmem_access_ctrl #(
  parameter int ADDR_W    = 10,
  parameter int MEM_BYTES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_wr,
  input  logic [2:0]        req_re,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              mem_work,
  output logic [1:0]        mem_DMWr,
  output logic [2:0]        mem_DMRe,
  output logic [ADDR_W-1:0] mem_Addr,
  output logic [31:0]       mem_DataIn,
  input  logic [31:0]       mem_DataOut,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [31:0]       rsp_rdata
);

  localparam logic [1:0] DMWR_NOP = 2'd0;
  localparam logic [1:0] DMWR_SW  = 2'd1;
  localparam logic [1:0] DMWR_SH  = 2'd2;
  localparam logic [1:0] DMWR_SB  = 2'd3;

  localparam logic [2:0] DMRE_NOP = 3'd0;
  localparam logic [2:0] DMRE_LW  = 3'd1;
  localparam logic [2:0] DMRE_LH  = 3'd2;
  localparam logic [2:0] DMRE_LHU = 3'd3;
  localparam logic [2:0] DMRE_LB  = 3'd4;
  localparam logic [2:0] DMRE_LBU = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t state_q, state_d;

  logic              work_q, work_d;
  logic [1:0]        dmwr_q, dmwr_d;
  logic [2:0]        dmre_q, dmre_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       din_q, din_d;
  logic              vld_q, vld_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;

  logic        is_wr, is_rd, req_nop;
  logic        bad_code, misalign, oor, req_err;
  logic [2:0]  size;
  logic [32:0] last_byte;

  assign is_wr   = (req_wr != DMWR_NOP);
  assign is_rd   = (req_re != DMRE_NOP);
  assign req_nop = !is_wr && !is_rd;

  always_comb begin
    size     = 3'd0;
    bad_code = 1'b0;
    if (is_wr) begin
      unique case (req_wr)
        DMWR_SW: size = 3'd4;
        DMWR_SH: size = 3'd2;
        DMWR_SB: size = 3'd1;
        default: size = 3'd0;
      endcase
    end else if (is_rd) begin
      unique case (req_re)
        DMRE_LW:  size = 3'd4;
        DMRE_LH:  size = 3'd2;
        DMRE_LHU: size = 3'd2;
        DMRE_LB:  size = 3'd1;
        DMRE_LBU: size = 3'd1;
        default:  bad_code = 1'b1;
      endcase
    end
  end

  // 33-bit sum so an address near 2^32 cannot wrap into range
  assign last_byte = {1'b0, req_addr} + 33'(size) - 33'd1;
  assign oor       = (size != 3'd0) &&
                     (last_byte > 33'(MEM_BYTES - 1));
  assign misalign  = ((size == 3'd4) && (req_addr[1:0] != 2'b00)) ||
                     ((size == 3'd2) && req_addr[0]);
  assign req_err   = (is_wr && is_rd) || bad_code || misalign || oor;

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    dmwr_d  = dmwr_q;
    dmre_d  = dmre_q;
    addr_d  = addr_q;
    din_d   = din_q;
    vld_d   = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (req_err || req_nop) begin
            state_d = S_RESP;
            vld_d   = 1'b1;
            err_d   = req_err;
          end else begin
            state_d = S_ACCESS;
            work_d  = 1'b1;
            dmwr_d  = req_wr;
            dmre_d  = req_re;
            addr_d  = req_addr[ADDR_W-1:0];
            din_d   = req_wdata;
          end
        end
      end
      S_ACCESS: begin
        // DMRe back to NOP forces a re-read on the next same-address load
        if (dmre_q != DMRE_NOP) rdata_d = mem_DataOut;
        work_d  = 1'b0;
        dmwr_d  = DMWR_NOP;
        dmre_d  = DMRE_NOP;
        vld_d   = 1'b1;
        state_d = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      work_q  <= 1'b0;
      dmwr_q  <= DMWR_NOP;
      dmre_q  <= DMRE_NOP;
      addr_q  <= '0;
      din_q   <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      dmwr_q  <= dmwr_d;
      dmre_q  <= dmre_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign mem_work   = work_q;
  assign mem_DMWr   = dmwr_q;
  assign mem_DMRe   = dmre_q;
  assign mem_Addr   = addr_q;
  assign mem_DataIn = din_q;
  assign rsp_valid  = vld_q;
  assign rsp_err    = err_q;
  assign rsp_rdata  = rdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: directed stimulus, byte-array memory, and a
// timeline model (accept cycle -> access/response cycles) checked every cycle.
module tb_dmem_access_ctrl;

  localparam logic [1:0] NWR = 2'd0, SW = 2'd1, SH = 2'd2, SB = 2'd3;
  localparam logic [2:0] NRE = 3'd0, LW = 3'd1, LH = 3'd2, LHU = 3'd3;
  localparam logic [2:0] LB = 3'd4, LBU = 3'd5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_wr = NWR;
  logic [2:0]  req_re = NRE;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        mem_work;
  logic [1:0]  mem_DMWr;
  logic [2:0]  mem_DMRe;
  logic [9:0]  mem_Addr;
  logic [31:0] mem_DataIn;
  logic [31:0] mem_DataOut;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  dmem_access_ctrl #(.ADDR_W(10), .MEM_BYTES(1024)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_re(req_re),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_work(mem_work), .mem_DMWr(mem_DMWr), .mem_DMRe(mem_DMRe),
    .mem_Addr(mem_Addr), .mem_DataIn(mem_DataIn),
    .mem_DataOut(mem_DataOut),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ld(input logic [2:0] re,
      input logic [7:0] b0, b1, b2, b3);
    case (re)
      LW:  return {b3, b2, b1, b0};
      LH:  return {{16{b1[7]}}, b1, b0};
      LHU: return {16'h0, b1, b0};
      LB:  return {{24{b0[7]}}, b0};
      LBU: return {24'h0, b0};
      default: return 32'h0;
    endcase
  endfunction

  // memory behind the port (not reset, like the real block)
  logic [7:0] env_mem [1024];
  logic [7:0] ref_mem [1024];

  always_comb begin
    mem_DataOut = ld(mem_DMRe, env_mem[mem_Addr],
                     env_mem[(int'(mem_Addr) + 1) % 1024],
                     env_mem[(int'(mem_Addr) + 2) % 1024],
                     env_mem[(int'(mem_Addr) + 3) % 1024]);
  end

  always @(posedge clk) begin
    if (mem_work) begin
      case (mem_DMWr)
        SW: begin
          env_mem[mem_Addr]     <= mem_DataIn[7:0];
          env_mem[mem_Addr + 1] <= mem_DataIn[15:8];
          env_mem[mem_Addr + 2] <= mem_DataIn[23:16];
          env_mem[mem_Addr + 3] <= mem_DataIn[31:24];
        end
        SH: begin
          env_mem[mem_Addr]     <= mem_DataIn[7:0];
          env_mem[mem_Addr + 1] <= mem_DataIn[15:8];
        end
        SB: env_mem[mem_Addr] <= mem_DataIn[7:0];
        default: ;
      endcase
    end
  end

  // ---- reference model: timeline of one accepted request ----
  int          cyc = 0;
  int          acc_cyc = -10;
  int          rsp_cyc = -10;
  int          idle_cyc = 0;
  logic        exp_err = 1'b0;
  logic [31:0] exp_rdata = '0;
  logic        p_access = 1'b0;
  logic [1:0]  p_wr;
  logic [2:0]  p_re;
  logic [31:0] p_addr, p_data;

  function automatic logic exp_error(input logic [1:0] wr,
      input logic [2:0] re, input logic [31:0] a, output logic nop);
    int sz;
    longint last;
    nop = (wr == NWR) && (re == NRE);
    if (wr != NWR && re != NRE) return 1'b1;
    if (nop) return 1'b0;
    if (wr == SW || re == LW) sz = 4;
    else if (wr == SH || re == LH || re == LHU) sz = 2;
    else sz = 1;
    if (a % sz != 0) return 1'b1;
    last = longint'(a) + longint'(sz) - 1;
    return last > 1023;
  endfunction

  always @(posedge clk) begin
    logic nop, e;
    int a;
    cyc++;
    if (p_access && cyc == acc_cyc + 1) begin
      a = int'(p_addr[9:0]);
      case (p_wr)
        SW: for (int k = 0; k < 4; k++) ref_mem[a + k] = p_data[8*k +: 8];
        SH: for (int k = 0; k < 2; k++) ref_mem[a + k] = p_data[8*k +: 8];
        SB: ref_mem[a] = p_data[7:0];
        default: ;
      endcase
      if (p_re != NRE && !rst)
        exp_rdata = ld(p_re, ref_mem[a], ref_mem[(a + 1) % 1024],
                       ref_mem[(a + 2) % 1024], ref_mem[(a + 3) % 1024]);
      p_access = 1'b0;
    end
    if (rst) begin
      acc_cyc   = -10;
      rsp_cyc   = -10;
      idle_cyc  = cyc;
      exp_rdata = '0;
      p_access  = 1'b0;
    end else if (cyc - 1 >= idle_cyc && req_valid) begin
      e = exp_error(req_wr, req_re, req_addr, nop);
      exp_err = e;
      if (e || nop) begin
        rsp_cyc  = cyc;
        idle_cyc = cyc + 1;
      end else begin
        acc_cyc  = cyc;
        rsp_cyc  = cyc + 1;
        idle_cyc = cyc + 2;
        p_access = 1'b1;
        p_wr     = req_wr;
        p_re     = req_re;
        p_addr   = req_addr;
        p_data   = req_wdata;
      end
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("ready", 32'(req_ready), 32'(cyc >= idle_cyc));
      chk("work", 32'(mem_work), 32'(cyc == acc_cyc));
      chk("rsp_valid", 32'(rsp_valid), 32'(cyc == rsp_cyc));
      if (cyc == rsp_cyc)
        chk("rsp_err", 32'(rsp_err), 32'(exp_err));
      chk("rsp_rdata", rsp_rdata, exp_rdata);
      if (cyc == acc_cyc) begin
        chk("Addr", 32'(mem_Addr), 32'(p_addr[9:0]));
        chk("DataIn", mem_DataIn, p_data);
        chk("DMWr", 32'(mem_DMWr), 32'(p_wr));
        chk("DMRe", 32'(mem_DMRe), 32'(p_re));
      end else begin
        chk("DMWr_idle", 32'(mem_DMWr), 32'(NWR));
        chk("DMRe_idle", 32'(mem_DMRe), 32'(NRE));
      end
    end
  end

  // ---- directed stimulus ----
  task automatic send(input logic [1:0] wr, input logic [2:0] re,
      input logic [31:0] a, input logic [31:0] d, input bit hold);
    logic r;
    bit ok;
    req_wr = wr; req_re = re; req_addr = a; req_wdata = d;
    req_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      r = req_ready;
      @(posedge clk);
      #1;
      ok = r;
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat, output logic err);
    lat = 0;
    err = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) begin
        err = rsp_err;
        return;
      end
    end
    chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic op(input string nm, input logic [1:0] wr,
      input logic [2:0] re, input logic [31:0] a, input logic [31:0] d,
      input int lat_exp, input logic err_exp);
    int lat;
    logic err;
    send(wr, re, a, d, 1'b0);
    wait_rsp(lat, err);
    chk({nm, "_lat"}, 32'(lat), 32'(lat_exp));
    chk({nm, "_err"}, 32'(err), 32'(err_exp));
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      env_mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_addr", 32'(mem_Addr), 32'd0);
    chk("rst_din", mem_DataIn, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);

    op("sw10", SW, NRE, 32'h10, 32'hDEADBEEF, 2, 1'b0);
    op("lw10", NWR, LW, 32'h10, 32'h0, 2, 1'b0);
    chk("lw10_data", rsp_rdata, 32'hDEADBEEF);

    op("sb21", SB, NRE, 32'h21, 32'h80, 2, 1'b0);
    op("lb21", NWR, LB, 32'h21, 32'h0, 2, 1'b0);
    chk("lb21_data", rsp_rdata, 32'hFFFFFF80);
    chk("lb21_dmre_nop", 32'(mem_DMRe), 32'(NRE));
    op("lbu21", NWR, LBU, 32'h21, 32'h0, 2, 1'b0);
    chk("lbu21_data", rsp_rdata, 32'h00000080);

    op("lw13", NWR, LW, 32'h13, 32'h0, 1, 1'b1);
    op("lh05", NWR, LH, 32'h05, 32'h0, 1, 1'b1);
    op("sw3fe", SW, NRE, 32'h3FE, 32'h1, 1, 1'b1);
    op("sb400", SB, NRE, 32'h400, 32'h1, 1, 1'b1);
    op("lbffff", NWR, LB, 32'hFFFFFFFF, 32'h0, 1, 1'b1);
    chk("err_keeps_rdata", rsp_rdata, 32'h00000080);

    op("sw3fc", SW, NRE, 32'h3FC, 32'hCAFEF00D, 2, 1'b0);
    op("lhu3fe", NWR, LHU, 32'h3FE, 32'h0, 2, 1'b0);
    chk("lhu3fe_data", rsp_rdata, 32'h0000CAFE);
    op("lb3ff", NWR, LB, 32'h3FF, 32'h0, 2, 1'b0);
    chk("lb3ff_data", rsp_rdata, 32'hFFFFFFCA);

    op("sw_lw", SW, LW, 32'h10, 32'h0, 1, 1'b1);
    op("nop", NWR, NRE, 32'h10, 32'h0, 1, 1'b0);
    chk("nop_rdata", rsp_rdata, 32'hFFFFFFCA);

    send(SW, NRE, 32'h80, 32'h11223344, 1'b1);
    send(SH, NRE, 32'h84, 32'h0000BEEF, 1'b1);
    send(NWR, LW, 32'h80, 32'h0, 1'b1);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("stream_data", rsp_rdata, 32'h11223344);
    op("lh84", NWR, LH, 32'h84, 32'h0, 2, 1'b0);
    chk("lh84_data", rsp_rdata, 32'hFFFFBEEF);

    send(SW, NRE, 32'h40, 32'h12345678, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_work", 32'(mem_work), 32'd0);
    chk("mid_rst_addr", 32'(mem_Addr), 32'd0);
    chk("mid_rst_din", mem_DataIn, 32'd0);
    chk("mid_rst_rdata", rsp_rdata, 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    repeat (2) @(negedge clk);
    op("lw40", NWR, LW, 32'h40, 32'h0, 2, 1'b0);
    chk("lw40_data", rsp_rdata, 32'h12345678);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
